// File: rtl/sa_operand_sequencer.sv
// Operand feeder for the systolic tile: holds A and W, streams them diagonally skewed onto the row/column edges.
// Latency: first beat and acc_clr appear one cycle after the start edge; done follows the last drain beat by one cycle.
// Backpressure: enable low freezes everything; load_ready drops outside IDLE or when start is present. Optional run_count via SEQ_RUN_COUNT_EN.
module sa_operand_sequencer #(
  parameter int SIZE  = 4,
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic                      load_sel,
  input  logic [$clog2(SIZE)-1:0]   load_row,
  input  logic [SIZE*WIDTH-1:0]     load_data,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      acc_clr,
  output logic                      out_valid,
  output logic [SIZE*WIDTH-1:0]     x_out,
  output logic [SIZE*WIDTH-1:0]     w_out
`ifdef SEQ_RUN_COUNT_EN
  ,
  output logic [15:0]               run_count
`endif
);

  localparam int              T_W    = $clog2(3*SIZE);
  localparam logic [T_W-1:0]  T_LAST = T_W'(3*SIZE-3);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [T_W-1:0]         t_q;
  logic [T_W-1:0]         beat_t;
  logic [WIDTH-1:0]       a_mem [SIZE][SIZE];
  logic [WIDTH-1:0]       w_mem [SIZE][SIZE];
  logic [SIZE*WIDTH-1:0]  x_beat;
  logic [SIZE*WIDTH-1:0]  w_beat;
  logic [SIZE*WIDTH-1:0]  x_q;
  logic [SIZE*WIDTH-1:0]  w_q;
  logic                   acc_clr_q;
  logic                   out_valid_q;
  logic                   start_run;
  logic                   step;
  logic                   finish;
  logic                   load_fire;

  assign start_run = enable && (state_q == S_IDLE) && start;
  assign step      = enable && (state_q == S_RUN) && (t_q != T_LAST);
  assign finish    = enable && (state_q == S_RUN) && (t_q == T_LAST);
  assign load_fire = load_valid && load_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_run) state_d = S_RUN;
      S_RUN:   if (finish)    state_d = S_DONE;
      S_DONE:  if (enable)    state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == S_RUN);
    done       = (state_q == S_DONE);
    load_ready = enable && (state_q == S_IDLE) && !start;
  end

  // Beat t puts A[i][k] on row lane i and W[k][i] on column lane i wherever i+k == t.
  assign beat_t = start_run ? '0 : t_q + 1'b1;

  always_comb begin
    x_beat = '0;
    w_beat = '0;
    for (int i = 0; i < SIZE; i++) begin
      for (int k = 0; k < SIZE; k++) begin
        if (int'(beat_t) == i + k) begin
          x_beat[i*WIDTH +: WIDTH] = a_mem[i][k];
          w_beat[i*WIDTH +: WIDTH] = w_mem[k][i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < SIZE; r++) begin
        for (int c = 0; c < SIZE; c++) begin
          a_mem[r][c] <= '0;
          w_mem[r][c] <= '0;
        end
      end
    end else if (load_fire) begin
      for (int c = 0; c < SIZE; c++) begin
        if (load_sel) begin
          w_mem[load_row][c] <= load_data[c*WIDTH +: WIDTH];
        end else begin
          a_mem[load_row][c] <= load_data[c*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_q         <= '0;
      acc_clr_q   <= 1'b0;
      out_valid_q <= 1'b0;
      x_q         <= '0;
      w_q         <= '0;
    end else if (enable) begin
      acc_clr_q <= start_run;
      if (start_run || step) begin
        t_q         <= beat_t;
        out_valid_q <= 1'b1;
        x_q         <= x_beat;
        w_q         <= w_beat;
      end else begin
        out_valid_q <= 1'b0;
        x_q         <= '0;
        w_q         <= '0;
      end
    end
  end

  assign acc_clr   = acc_clr_q;
  assign out_valid = out_valid_q;
  assign x_out     = x_q;
  assign w_out     = w_q;

`ifdef SEQ_RUN_COUNT_EN
  logic [15:0] run_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_count_q <= '0;
    end else if (finish && (run_count_q != 16'hFFFF)) begin
      run_count_q <= run_count_q + 16'd1;
    end
  end

  assign run_count = run_count_q;
`endif

endmodule
